reg_read_scoreboard: RTL and testbench

- Consumer-side operand reader for the 15-entry ARM register file: it drives the two read addresses, captures `reg_1`/`reg_2` into a registered operand stage, and tracks in-flight writes with per-register pending counters.
- Sits between decode and execute: decode issues through a valid/ready handshake, and execute drains the operand stage.
- Issue stalls while a source register has an outstanding write-back not yet landing in the register file.
- Write-back is snooped from the same `write_back_en`/`dest_wb` bus that feeds the register file. The register file writes on the falling edge, so a write completing in cycle N is readable at the rising edge ending cycle N.

---
 rtl/reg_read_scoreboard_if.sv | 45 ++++
 rtl/reg_read_scoreboard.sv | 104 ++++++++++
 tb/tb_reg_read_scoreboard.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_read_scoreboard_if.sv
// Decode/register-file/write-back/execute signal bundle for the operand reader.
// The slave modport is the reader's view; master is the surrounding pipeline.
interface reg_read_scoreboard_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [3:0]            issue_src_1;
  logic [3:0]            issue_src_2;
  logic                  issue_use_1;
  logic                  issue_use_2;
  logic [3:0]            issue_dest;
  logic                  issue_wb_en;

  logic [3:0]            rf_src_1;
  logic [3:0]            rf_src_2;
  logic [DATA_WIDTH-1:0] rf_reg_1;
  logic [DATA_WIDTH-1:0] rf_reg_2;

  logic                  write_back_en;
  logic [3:0]            dest_wb;

  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [3:0]            op_dest;
  logic                  op_wb_en;

  modport master (
    output issue_valid, issue_src_1, issue_src_2, issue_use_1, issue_use_2,
           issue_dest, issue_wb_en, rf_reg_1, rf_reg_2, write_back_en,
           dest_wb, op_ready,
    input  issue_ready, rf_src_1, rf_src_2, op_valid, op_a, op_b, op_dest,
           op_wb_en
  );

  modport slave (
    input  issue_valid, issue_src_1, issue_src_2, issue_use_1, issue_use_2,
           issue_dest, issue_wb_en, rf_reg_1, rf_reg_2, write_back_en,
           dest_wb, op_ready,
    output issue_ready, rf_src_1, rf_src_2, op_valid, op_a, op_b, op_dest,
           op_wb_en
  );
endinterface

// File: rtl/reg_read_scoreboard.sv
// Operand reader for the ARM register file: stalls issue on pending write-backs,
// captures read data into a one-entry operand stage drained by execute.
module reg_read_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 15,
  parameter int CNT_WIDTH  = 2
) (
  input logic                  clk,
  input logic                  rst,
  reg_read_scoreboard_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]  cnt [NUM_REGS];

  // Per-index views padded to 16 so any 4-bit index is in range; untracked
  // indices (the PC) always read as clear and never full.
  logic [15:0]           land_vec;
  logic [15:0]           clear_vec;
  logic [15:0]           full_vec;
  logic [15:0]           inc_vec;

  logic                  hazard;
  logic                  accept;

  logic                  op_valid_q;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  logic [3:0]            op_dest_q;
  logic                  op_wb_en_q;

  // A write landing this cycle is already visible in the register file at the
  // rising edge, so a count of one that is landing counts as clear.
  always_comb begin
    land_vec  = '0;
    clear_vec = '1;
    full_vec  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      land_vec[r]  = bus.write_back_en && (bus.dest_wb == 4'(r));
      clear_vec[r] = (cnt[r] == '0) || ((cnt[r] == CNT_ONE) && land_vec[r]);
      full_vec[r]  = (cnt[r] == CNT_MAX) && !land_vec[r];
    end
  end

  always_comb begin
    inc_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = accept && bus.issue_wb_en && (bus.issue_dest == 4'(r));
    end
  end

  assign hazard = (bus.issue_use_1 && !clear_vec[bus.issue_src_1]) ||
                  (bus.issue_use_2 && !clear_vec[bus.issue_src_2]) ||
                  (bus.issue_wb_en && full_vec[bus.issue_dest]);

  assign bus.issue_ready = !hazard && (!op_valid_q || bus.op_ready);
  assign accept          = bus.issue_valid && bus.issue_ready;

  assign bus.rf_src_1 = bus.issue_src_1;
  assign bus.rf_src_2 = bus.issue_src_2;

  // Simultaneous issue and landing on one register cancel; a landing with
  // nothing outstanding is tolerated and leaves the count at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !land_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (land_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_dest_q  <= '0;
      op_wb_en_q <= 1'b0;
    end else if (accept) begin
      op_valid_q <= 1'b1;
      op_a_q     <= bus.issue_use_1 ? bus.rf_reg_1 : '0;
      op_b_q     <= bus.issue_use_2 ? bus.rf_reg_2 : '0;
      op_dest_q  <= bus.issue_dest;
      op_wb_en_q <= bus.issue_wb_en;
    end else if (bus.op_ready) begin
      op_valid_q <= 1'b0;
    end
  end

  assign bus.op_valid = op_valid_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.op_dest  = op_dest_q;
  assign bus.op_wb_en = op_wb_en_q;

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Bench for reg_read_scoreboard: table of per-cycle vectors with expected
// issue_ready, a queue of expected operand-stage contents, and a reset corner.
module tb_reg_read_scoreboard;

  localparam int DW = 32;

  typedef struct {
    logic          valid;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic          u1;
    logic          u2;
    logic [3:0]    d;
    logic          wb;
    logic          wbe;
    logic [3:0]    dwb;
    logic [DW-1:0] wbd;
    logic          opr;
    logic          exp_ready;
    int            creg;
    int            ccnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    dest;
    logic          wb;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_read_scoreboard_if #(.DATA_WIDTH(DW)) bus ();

  reg_read_scoreboard #(
    .DATA_WIDTH(DW),
    .NUM_REGS  (15),
    .CNT_WIDTH (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Register file model: falling-edge write, combinational read.
  logic [DW-1:0] rf_mem [16];
  logic [DW-1:0] wb_data;

  assign bus.rf_reg_1 = rf_mem[bus.rf_src_1];
  assign bus.rf_reg_2 = rf_mem[bus.rf_src_2];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= DW'(i);
    end else if (bus.write_back_en) begin
      rf_mem[bus.dest_wb] <= wb_data;
    end
  end

  int   nAssert = 0;
  int   nFail   = 0;
  op_t  sbq [$];
  op_t  exp_op;
  logic exp_valid;
  vec_t vecs [$];

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAllCntZero(input string name);
    for (int r = 0; r < 15; r++) checkValue(name, 32'(dut.cnt[r]), 32'd0);
  endtask

  function automatic vec_t mk(input int valid, input int s1, input int s2, input int u1,
                              input int u2, input int d, input int wb, input int wbe,
                              input int dwb, input int wbd, input int opr, input int er,
                              input int creg, input int ccnt);
    vec_t v;
    v.valid = valid[0]; v.s1 = 4'(s1); v.s2 = 4'(s2); v.u1 = u1[0]; v.u2 = u2[0];
    v.d = 4'(d); v.wb = wb[0]; v.wbe = wbe[0]; v.dwb = 4'(dwb); v.wbd = DW'(wbd);
    v.opr = opr[0]; v.exp_ready = er[0]; v.creg = creg; v.ccnt = ccnt;
    return v;
  endfunction

  task automatic driveIdle();
    bus.issue_valid   = 1'b0;
    bus.issue_src_1   = '0;
    bus.issue_src_2   = '0;
    bus.issue_use_1   = 1'b0;
    bus.issue_use_2   = 1'b0;
    bus.issue_dest    = '0;
    bus.issue_wb_en   = 1'b0;
    bus.write_back_en = 1'b0;
    bus.dest_wb       = '0;
    bus.op_ready      = 1'b1;
    wb_data           = '0;
  endtask

  // Update the expected operand stage, then compare every op_* output.
  task automatic checkOutput(input logic accepted, input logic opr);
    if (accepted) begin
      if (sbq.size() == 0) begin
        nFail++;
        $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
        exp_op    = sbq.pop_front();
        exp_valid = 1'b1;
      end
    end else if (opr) begin
      exp_valid = 1'b0;
    end
    checkValue("op_valid", 32'(bus.op_valid), 32'(exp_valid));
    checkValue("op_a", bus.op_a, exp_op.a);
    checkValue("op_b", bus.op_b, exp_op.b);
    checkValue("op_dest", 32'(bus.op_dest), 32'(exp_op.dest));
    checkValue("op_wb_en", 32'(bus.op_wb_en), 32'(exp_op.wb));
  endtask

  // Called at posedge+1; drives one cycle and checks it.
  task automatic applyStimulus(input vec_t v);
    logic accepted;
    op_t  e;
    bus.issue_valid   = v.valid;
    bus.issue_src_1   = v.s1;
    bus.issue_src_2   = v.s2;
    bus.issue_use_1   = v.u1;
    bus.issue_use_2   = v.u2;
    bus.issue_dest    = v.d;
    bus.issue_wb_en   = v.wb;
    bus.write_back_en = v.wbe;
    bus.dest_wb       = v.dwb;
    wb_data           = v.wbd;
    bus.op_ready      = v.opr;
    @(negedge clk);
    #1;
    checkValue("issue_ready", 32'(bus.issue_ready), 32'(v.exp_ready));
    checkValue("rf_src_1", 32'(bus.rf_src_1), 32'(v.s1));
    checkValue("rf_src_2", 32'(bus.rf_src_2), 32'(v.s2));
    accepted = v.valid && v.exp_ready;
    if (accepted) begin
      e.a    = v.u1 ? rf_mem[v.s1] : '0;
      e.b    = v.u2 ? rf_mem[v.s2] : '0;
      e.dest = v.d;
      e.wb   = v.wb;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    checkOutput(accepted, v.opr);
    if (v.creg >= 0 && v.creg < 15) begin
      checkValue($sformatf("cnt[%0d]", v.creg), 32'(dut.cnt[v.creg]), 32'(v.ccnt));
    end
  endtask

  initial begin
    driveIdle();
    exp_valid = 1'b0;
    exp_op    = '{a: '0, b: '0, dest: '0, wb: 1'b0};

    //            vld s1 s2 u1 u2 d  wb wbe dwb wbd     opr rdy creg cnt
    // Basic read, then RAW stall on r5 until its write-back lands.
    vecs.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0,      1, 1,  5, 1));
    vecs.push_back(mk(1, 5, 0, 1, 0, 6, 0, 0, 0, 0,      1, 0,  5, 1));
    vecs.push_back(mk(0, 0, 5, 0, 1, 6, 0, 0, 0, 0,      1, 0, -1, 0));
    vecs.push_back(mk(1, 5, 0, 1, 0, 6, 0, 0, 0, 0,      1, 0,  5, 1));
    vecs.push_back(mk(1, 5, 0, 1, 0, 6, 0, 1, 5, 'hAA,   1, 1,  5, 0));
    // Saturation of r2, landing-cycle release, drain and spurious landing.
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,      1, 1,  2, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,      1, 1,  2, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,      1, 1,  2, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,      1, 0,  2, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 2, 'h22,   1, 1,  2, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 'h22,   1, 1,  2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 'h22,   1, 1,  2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 'h22,   1, 1,  2, 0));
    vecs.push_back(mk(1, 2, 0, 1, 0, 0, 0, 1, 2, 'h22,   1, 1,  2, 0));
    // Backpressure from execute.
    vecs.push_back(mk(1, 3, 4, 1, 1, 8, 0, 0, 0, 0,      1, 1, -1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 9, 0, 0, 0, 0,      0, 0, -1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 9, 0, 0, 0, 0,      0, 0, -1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 9, 0, 0, 0, 0,      1, 1, -1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 1, -1, 0));
    // Issue and landing on r7 together; index 15 is never tracked.
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,      1, 1,  7, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 7, 'h77,   1, 1,  7, 1));
    vecs.push_back(mk(1, 15, 15, 1, 1, 15, 1, 1, 15, 'hF0, 1, 1, 7, 1));
    vecs.push_back(mk(1, 15, 0, 1, 0, 15, 1, 0, 0, 0,    1, 1,  7, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 'h77,   1, 1,  7, 0));
    // Build up two pending writes on r5 ahead of the async reset.
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,      1, 1,  5, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,      1, 1,  5, 2));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] reset released");
    checkOutput(1'b0, 1'b1);
    checkAllCntZero("reset_cnt");
    checkValue("reset_issue_ready", 32'(bus.issue_ready), 32'd1);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Asynchronous reset mid-cycle while cnt[5]=2 and op_valid=1.
    checkValue("pre_rst_op_valid", 32'(bus.op_valid), 32'd1);
    driveIdle();
    #2;
    rst = 1'b1;
    #1;
    checkValue("async_rst_op_valid", 32'(bus.op_valid), 32'd0);
    checkValue("async_rst_op_a", bus.op_a, 32'd0);
    checkValue("async_rst_op_dest", 32'(bus.op_dest), 32'd0);
    checkAllCntZero("async_rst_cnt");
    @(negedge clk);
    rst = 1'b0;
    exp_valid = 1'b0;
    exp_op    = '{a: '0, b: '0, dest: '0, wb: 1'b0};
    sbq.delete();
    @(posedge clk);
    #1;
    checkOutput(1'b0, 1'b1);
    applyStimulus(mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 1, 1, 5, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, -1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
